imem_program_loader: RTL
========================

Name: imem_program_loader

Overview:
- Writer side of the instruction-memory read path: fills instruction memory before the processor fetches from it.
- Accepts a byte stream on a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one write per word at byte addresses matching the 64-bit PC, starting at BASE_ADDR.
- Holds the processor in reset (cpu_reset) until a load completes cleanly.

Parameters:
- IMEM_WORDS, 64, capacity of instruction memory in 32-bit words.
- BASE_ADDR, 0, byte address of the first word written.
- LEN_W, 16, width of the word_count input.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- word_count  in  LEN_W  number of words to load; latched on accepted start.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  stream byte, little-endian within each word.
- byte_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  64  byte address of the write, BASE_ADDR + 4*word_idx.
- imem_wdata  out  32  assembled instruction word.
- busy  out  1  high in RECV or WRITE.
- done  out  1  high in DONE.
- err  out  1  load rejected or corrupt; sticky until the next accepted start.
- cpu_reset  out  1  active-high hold for the processor; low only in DONE with err=0.

Behaviour:
- Reset (reset=0, async): state=IDLE.
  - Outputs: byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, err=0, cpu_reset=1.
  - Internal: byte_cnt=0, word_idx=0, shift register=0.
- Reset mid-load: abandons the load immediately. Words already written remain in memory, and cpu_reset stays 1.
- Accepting start (IDLE or DONE): latch word_count into len, clear err, set word_idx=0 and byte_cnt=0, set cpu_reset=1.
  - len==0: go to DONE next cycle with err=0.
  - len>IMEM_WORDS: go to DONE with err=1; nothing is written.
  - Otherwise: go to RECV.
- start is ignored in RECV and WRITE.
- RECV: byte_ready=1. A byte is transferred only on byte_valid & byte_ready in the same cycle.
  - Byte k (k=0..3) goes into bits [8k+7:8k].
  - byte_cnt increments and wraps 3->0.
  - On the 4th byte, go to WRITE. byte_ready drops in the following cycle, so no byte is accepted while in WRITE.
- Stalls: byte_valid low stalls RECV indefinitely; no timeout.
- WRITE: lasts exactly one cycle.
  - imem_we=1, imem_addr=BASE_ADDR+4*word_idx, imem_wdata=assembled word.
  - Then word_idx increments.
  - If word_idx+1==len, go to DONE; otherwise return to RECV.
- Latency: from the 4th byte handshake, imem_we rises on the next clock edge.
  - Throughput is 5 cycles per word with a continuous stream.
- DONE: done=1, busy=0, byte_ready=0, cpu_reset=!err. Holds until a new start.
- imem_we is never asserted outside WRITE. The address never exceeds BASE_ADDR+4*(IMEM_WORDS-1).

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
  - Defined: after the last WRITE, the FSM enters CHK with byte_ready=1 and accepts one extra byte. It compares that byte with the running XOR of all data bytes.
    - Mismatch: err=1, cpu_reset stays 1.
    - Either way, go to DONE.
    - The XOR accumulator is cleared on accepted start.
    - For len==0, no checksum byte is expected.
  - Undefined: no CHK state and no accumulator; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then start with word_count=2, stream bytes 13 05 10 00 93 05 20 00 with valid held high.
  - Expect imem_we pulses: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593.
  - Then done=1, cpu_reset=0, err=0.
- Same load with byte_valid toggling every other cycle.
  - Expect identical writes and data; no byte lost or duplicated.
  - byte_ready=0 during each WRITE cycle.
- Start with word_count=IMEM_WORDS+1.
  - Expect next cycle done=1, err=1, cpu_reset=1, and no imem_we.
- Start with word_count=0: done=1 next cycle, err=0, cpu_reset=0, no writes.
- Pull reset low after 2 of 4 bytes.
  - Expect immediate IDLE values: cpu_reset=1, byte_ready=0, busy=0.
  - A new start with 1 word writes at BASE_ADDR.
- With LOADER_CHECKSUM_EN, load 1 word (13 05 10 00).
  - Checksum byte 0x06: err=0, cpu_reset=0.
  - Checksum byte 0x07: err=1, cpu_reset=1.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// master: the loader; slave: the byte source / memory side.
interface imem_program_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: packs a little-endian byte stream into 32-bit
// words, writes them from BASE_ADDR and holds cpu_reset until a clean load. Option: LOADER_CHECKSUM_EN.
module imem_program_loader #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_reset,
  imem_program_loader_if.master bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHK, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_e;
`endif

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [63:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              byte_ready_q, byte_ready_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              byte_fire;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  assign byte_fire = bus.byte_valid & byte_ready_q;

  // Next-state, datapath and next-output computation
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
`ifdef LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d      = word_count;
          err_d      = 1'b0;
          word_idx_d = '0;
          byte_cnt_d = 2'd0;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = 8'h00;
`endif
          if (word_count == '0) begin
            state_d = DONE;
          end else if (32'(word_count) > IMEM_WORDS) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (byte_fire) begin
          shift_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = xor_q ^ bus.byte_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
            addr_d  = BASE_ADDR + 64'({word_idx_q, 2'b00});
            wdata_d = {bus.byte_data, shift_q[23:0]};
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + LEN_W'(1);
        if (word_idx_q + LEN_W'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      // One trailing byte must equal the XOR of every data byte
      CHK: begin
        if (byte_fire) begin
          err_d   = (bus.byte_data != xor_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef LOADER_CHECKSUM_EN
    byte_ready_d = (state_d == RECV) || (state_d == CHK);
    busy_d       = (state_d == RECV) || (state_d == WRITE) || (state_d == CHK);
`else
    byte_ready_d = (state_d == RECV);
    busy_d       = (state_d == RECV) || (state_d == WRITE);
`endif
    we_d        = (state_d == WRITE);
    done_d      = (state_d == DONE);
    cpu_reset_d = !((state_d == DONE) && !err_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 32'h0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cpu_reset_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_idx_q   <= word_idx_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cpu_reset_q  <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign cpu_reset      = cpu_reset_q;

endmodule
